// File: rtl/splio_shifter_pkg.sv
// Shared definitions for the serial LED/GPIO shifter: FSM state encoding and counter sizing.
package splio_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/splio_shifter_bitclk.sv
// Bit-time generator: a phase counter that spans one bit (2*CLK_HALF cycles),
// driving the chain clock low for the first half and high for the second.
module splio_shifter_bitclk
  import splio_shifter_pkg::*;
#(
  parameter int CLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clk_en_i,
  output logic led_clk_o,
  output logic bit_start_o,
  output logic bit_end_o
);

  localparam int PW = cnt_w(2 * CLK_HALF);
  localparam logic [PW-1:0] HALF = PW'(CLK_HALF);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_HALF - 1);

  logic [PW-1:0] phase_q, phase_d;

  // The counter idles at zero so every run starts on a fresh bit boundary.
  always_comb begin
    phase_d = '0;
    if (run_i && (phase_q != LAST)) phase_d = phase_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign led_clk_o   = clk_en_i & (phase_q >= HALF);
  assign bit_start_o = run_i & (phase_q == '0);
  assign bit_end_o   = run_i & (phase_q == LAST);

endmodule

// File: rtl/splio_shifter.sv
// Serial-out shifter for a 74LS164-style LED/GPIO chain: shifts a frame on a
// Start rising edge, then commits it to the parallel shadow outputs.
module splio_shifter
  import splio_shifter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LED_W     = 16,
  parameter int CLK_HALF  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Start,
  input  logic                    EN,
  input  logic                    clr_req,
  input  logic [DATA_W-1:0]       P_Data,
  output logic                    busy,
  output logic                    done,
  output logic [LED_W-1:0]        LED,
  output logic [DATA_W-LED_W-1:0] GPIOf0,
  output logic                    led_clk,
  output logic                    led_sout,
  output logic                    led_clrn,
  output logic                    LED_PEN
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // Handshake: busy is high from the cycle after an accepted Start edge or a
  // clear request until done has pulsed; done pulses once per committed frame,
  // in the same cycle LED/GPIOf0 show the new frame. Start edges seen while
  // busy are dropped, a clr_req seen while shifting is held and served later.

  state_e            state_q, state_d;
  logic              start_q;
  logic              clr_pend_q, clr_pend_d;
  logic              start_pend_q, start_pend_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              pen_q, pen_d;

  logic start_edge, accept, bit_start, bit_end, run;

  assign start_edge = Start & ~start_q;
  assign accept     = start_edge & EN & (state_q == ST_IDLE);
  assign run        = (state_q == ST_SHIFT) | (state_q == ST_CLEAR);

  splio_shifter_bitclk #(.CLK_HALF(CLK_HALF)) u_bitclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run),
    .clk_en_i   (state_q == ST_SHIFT),
    .led_clk_o  (led_clk),
    .bit_start_o(bit_start),
    .bit_end_o  (bit_end)
  );

  always_comb begin
    state_d      = state_q;
    clr_pend_d   = clr_pend_q;
    start_pend_d = start_pend_q;
    frame_d      = frame_q;
    sreg_d       = sreg_q;
    shadow_d     = shadow_q;
    bit_d        = bit_q;
    pen_d        = pen_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) frame_d = P_Data;
        if (clr_req || clr_pend_q) begin
          // Clear wins over a simultaneous start; the start is remembered.
          state_d    = ST_CLEAR;
          clr_pend_d = 1'b0;
          shadow_d   = '0;
          if (accept) start_pend_d = 1'b1;
        end else if (accept || start_pend_q) begin
          state_d      = ST_SHIFT;
          start_pend_d = 1'b0;
          sreg_d       = accept ? P_Data : frame_q;
          bit_d        = '0;
          pen_d        = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (bit_end) begin
          if (start_pend_q) begin
            state_d      = ST_SHIFT;
            start_pend_d = 1'b0;
            sreg_d       = frame_q;
            bit_d        = '0;
            pen_d        = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SHIFT: begin
        if (clr_req) clr_pend_d = 1'b1;
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            state_d  = ST_DONE;
            shadow_d = frame_q;
            pen_d    = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            if (MSB_FIRST != 0) sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
            else                sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
          end
        end
      end
      ST_DONE: begin
        if (clr_req) clr_pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b1;
      clr_pend_q   <= 1'b0;
      start_pend_q <= 1'b0;
      frame_q      <= '0;
      sreg_q       <= '0;
      shadow_q     <= '0;
      bit_q        <= '0;
      pen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= Start;
      clr_pend_q   <= clr_pend_d;
      start_pend_q <= start_pend_d;
      frame_q      <= frame_d;
      sreg_q       <= sreg_d;
      shadow_q     <= shadow_d;
      bit_q        <= bit_d;
      pen_q        <= pen_d;
    end
  end

  // Serial data is taken straight from the register end, so it only moves
  // when the register shifts at a bit boundary.
  logic sout_raw;
  assign sout_raw = (MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0];

  assign led_sout = (state_q == ST_SHIFT) & sout_raw & (bit_start | ~bit_start);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign led_clrn = (state_q != ST_CLEAR);
  assign LED_PEN  = pen_q;
  assign LED      = shadow_q[LED_W-1:0];
  assign GPIOf0   = shadow_q[DATA_W-1:LED_W];

endmodule

// File: tb/tb_splio_shifter.sv
// Bench for splio_shifter: DATA_W=16, LED_W=8, CLK_HALF=2, with an MSB-first
// instance (a) and an LSB-first instance (b) sharing the same stimulus.
module tb_splio_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        EN;
  logic        clr_req;
  logic [15:0] P_Data;

  logic       busy_a, done_a, led_clk_a, led_sout_a, led_clrn_a, pen_a;
  logic [7:0] led_a, gpio_a;
  logic       busy_b, done_b, led_clk_b, led_sout_b, led_clrn_b, pen_b;
  logic [7:0] led_b, gpio_b;

  int checks = 0;
  int errors = 0;

  splio_shifter #(.DATA_W(16), .LED_W(8), .CLK_HALF(2), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .Start(Start), .EN(EN), .clr_req(clr_req),
    .P_Data(P_Data), .busy(busy_a), .done(done_a), .LED(led_a), .GPIOf0(gpio_a),
    .led_clk(led_clk_a), .led_sout(led_sout_a), .led_clrn(led_clrn_a),
    .LED_PEN(pen_a)
  );

  splio_shifter #(.DATA_W(16), .LED_W(8), .CLK_HALF(2), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .Start(Start), .EN(EN), .clr_req(clr_req),
    .P_Data(P_Data), .busy(busy_b), .done(done_b), .LED(led_b), .GPIOf0(gpio_b),
    .led_clk(led_clk_b), .led_sout(led_sout_b), .led_clrn(led_clrn_b),
    .LED_PEN(pen_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] seq_m;  // bit order seen on the MSB-first chain, first bit at [15]
    logic [15:0] seq_l;  // same for the LSB-first chain
    logic [7:0]  led;
    logic [7:0]  gpio;
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},     {31'd0, busy_a},     32'd0);
    check({tag, " done"},     {31'd0, done_a},     32'd0);
    check({tag, " LED"},      {24'd0, led_a},      32'd0);
    check({tag, " GPIOf0"},   {24'd0, gpio_a},     32'd0);
    check({tag, " led_clk"},  {31'd0, led_clk_a},  32'd0);
    check({tag, " led_sout"}, {31'd0, led_sout_a}, 32'd0);
    check({tag, " led_clrn"}, {31'd0, led_clrn_a}, 32'd1);
    check({tag, " LED_PEN"},  {31'd0, pen_a},      32'd0);
    check({tag, " b busy"},   {31'd0, busy_b},     32'd0);
  endtask

  // Driver + monitor for one frame. A second Start edge is raised during
  // bit 6 and P_Data/EN are disturbed mid-frame; none of it may show.
  task automatic run_frame(input string tag, input vec_t v, input bit pre_clr);
    int sh, lat, rises_a, rises_b, dones_a, dones_b, clrn_low, pen_bad, busy_bad;
    logic prev_a, prev_b;
    logic [15:0] cap_a, cap_b;
    sh = pre_clr ? 4 : 0;
    lat = 65 + sh;
    rises_a = 0; rises_b = 0; dones_a = 0; dones_b = 0;
    clrn_low = 0; pen_bad = 0; busy_bad = 0;
    prev_a = 1'b0; prev_b = 1'b0; cap_a = '0; cap_b = '0;
    Start = 1'b0; EN = 1'b1; clr_req = 1'b0;
    tick();
    Start = 1'b1; P_Data = v.data; clr_req = pre_clr;
    for (int c = 1; c <= lat + 2; c++) begin
      tick();
      if (led_clk_a && !prev_a) begin rises_a++; cap_a = {cap_a[14:0], led_sout_a}; end
      if (led_clk_b && !prev_b) begin rises_b++; cap_b = {cap_b[14:0], led_sout_b}; end
      prev_a = led_clk_a; prev_b = led_clk_b;
      if (done_a) dones_a++;
      if (done_b) dones_b++;
      if (!led_clrn_a) clrn_low++;
      if (c > sh && c < lat && pen_a) pen_bad++;
      if (c <= lat && !busy_a) busy_bad++;
      if (pre_clr && c == 1) check({tag, " LED cleared"}, {24'd0, led_a}, 32'd0);
      if (c == lat) begin
        check({tag, " done at latency"}, {31'd0, done_a}, 32'd1);
        check({tag, " LED"},    {24'd0, led_a},  {24'd0, v.led});
        check({tag, " GPIOf0"}, {24'd0, gpio_a}, {24'd0, v.gpio});
        check({tag, " b LED"},  {24'd0, led_b},  {24'd0, v.led});
        check({tag, " b GPIOf0"}, {24'd0, gpio_b}, {24'd0, v.gpio});
        check({tag, " LED_PEN at done"}, {31'd0, pen_a}, 32'd1);
      end
      // Inputs for the next cycle
      clr_req = 1'b0;
      if (c == 1)  begin P_Data = ~v.data; EN = 1'b0; end
      if (c == 24) begin Start = 1'b0; EN = 1'b1; end
      if (c == 25) Start = 1'b1;
      if (c == 30) EN = 1'b0;
    end
    check({tag, " clrn low cycles"}, clrn_low, sh);
    check({tag, " a rises"}, rises_a, 16);
    check({tag, " b rises"}, rises_b, 16);
    check({tag, " a bits"}, {16'd0, cap_a}, {16'd0, v.seq_m});
    check({tag, " b bits"}, {16'd0, cap_b}, {16'd0, v.seq_l});
    check({tag, " PEN high in shift"}, pen_bad, 0);
    check({tag, " busy gaps"}, busy_bad, 0);
    check({tag, " a done pulses"}, dones_a, 1);
    check({tag, " b done pulses"}, dones_b, 1);
    check({tag, " idle after"}, {31'd0, busy_a}, 32'd0);
    check({tag, " PEN held"}, {31'd0, pen_a}, 32'd1);
  endtask

  initial begin
    int busy_seen, dones;
    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5, 8'hC3, 8'hA5};
    vecs[1] = '{16'h0001, 16'h0001, 16'h8000, 8'h01, 8'h00};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0001, 8'h00, 8'h80};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF};
    vecs[4] = '{16'h1234, 16'h1234, 16'h2C48, 8'h34, 8'h12};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00};

    // Reset with Start held high; release must not trigger a frame.
    rst_n = 1'b0; Start = 1'b1; EN = 1'b1; clr_req = 1'b0; P_Data = 16'h5A5A;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy_a || busy_b) busy_seen++;
    end
    check("no frame after release", busy_seen, 0);

    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Start edge with EN low is dropped.
    Start = 1'b0; EN = 1'b0;
    tick();
    Start = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_a || busy_b || led_clk_a) busy_seen++;
    end
    check("EN=0 edge ignored", busy_seen, 0);

    // Clear and start in the same cycle, starting from LED=C3.
    run_frame("pre-clear", vecs[0], 1'b0);
    check("LED before clear", {24'd0, led_a}, 32'h0000_00C3);
    run_frame("clear+start", vecs[0], 1'b1);

    // Reset pulse during bit 5 abandons the frame.
    Start = 1'b0; EN = 1'b1;
    tick();
    Start = 1'b1; P_Data = 16'hA5C3;
    for (int c = 1; c <= 22; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("mid reset");
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done_a || done_b || busy_a) dones++;
    end
    check("no done after reset", dones, 0);
    run_frame("post-reset", vecs[4], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
